// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the SDRAM tunnel arbiters.
package sdram_arb_pkg;

  localparam int ADDR_W = 21;
  localparam int LEN_W  = 32;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    XFER   = 3'd2,
    FLUSH  = 3'd3,
    ABORT  = 3'd4
  } state_t;

  // Winner between two requesters; on a tie the client that was not served last wins.
  function automatic logic rr_pick(input logic p0, input logic p1, input logic last_grant);
    if (p0 && p1) return ~last_grant;
    return p1;
  endfunction

endpackage

// File: rtl/sdram_wr_tunnel_mux_if.sv
// Client and memory-port signals of the write tunnel mux, bundled for port lists.
interface sdram_wr_tunnel_mux_if;
  import sdram_arb_pkg::*;

  logic              i_wr_0_start;
  logic [ADDR_W-1:0] i_wr_0_addrs;
  logic [LEN_W-1:0]  i_wr_0_lengths;
  logic              i_wr_0_data_vld;
  logic [DATA_W-1:0] i_wr_0_data;
  logic              o_wr_0_data_req;
  logic              o_wr_0_done;

  logic              i_wr_1_start;
  logic [ADDR_W-1:0] i_wr_1_addrs;
  logic [LEN_W-1:0]  i_wr_1_lengths;
  logic              i_wr_1_data_vld;
  logic [DATA_W-1:0] i_wr_1_data;
  logic              o_wr_1_data_req;
  logic              o_wr_1_done;

  logic              o_tunnel_id;
  logic              o_busy;
  logic              o_mem_wr3_start;
  logic [ADDR_W-1:0] o_mem_wr3_addrs;
  logic [LEN_W-1:0]  o_mem_wr3_lens;
  logic              o_mem_wr3_data_vld;
  logic [DATA_W-1:0] o_mem_wr3_data;
  logic              i_mem_wr3_data_req;
  logic              i_mem_wr3_idle;

  modport slave (
    input  i_wr_0_start, i_wr_0_addrs, i_wr_0_lengths, i_wr_0_data_vld, i_wr_0_data,
    output o_wr_0_data_req, o_wr_0_done,
    input  i_wr_1_start, i_wr_1_addrs, i_wr_1_lengths, i_wr_1_data_vld, i_wr_1_data,
    output o_wr_1_data_req, o_wr_1_done,
    output o_tunnel_id, o_busy,
    output o_mem_wr3_start, o_mem_wr3_addrs, o_mem_wr3_lens, o_mem_wr3_data_vld, o_mem_wr3_data,
    input  i_mem_wr3_data_req, i_mem_wr3_idle
  );

  modport master (
    output i_wr_0_start, i_wr_0_addrs, i_wr_0_lengths, i_wr_0_data_vld, i_wr_0_data,
    input  o_wr_0_data_req, o_wr_0_done,
    output i_wr_1_start, i_wr_1_addrs, i_wr_1_lengths, i_wr_1_data_vld, i_wr_1_data,
    input  o_wr_1_data_req, o_wr_1_done,
    input  o_tunnel_id, o_busy,
    input  o_mem_wr3_start, o_mem_wr3_addrs, o_mem_wr3_lens, o_mem_wr3_data_vld, o_mem_wr3_data,
    output i_mem_wr3_data_req, i_mem_wr3_idle
  );

endinterface

// File: rtl/wr_client_req_edge.sv
// Per-client start-level edge detector: keeps the pending request flag and flags withdrawals.
module wr_client_req_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_grant,
  output logic o_pending,
  output logic o_abort
);

  logic start_dly_q, start_dly_d;
  logic pending_q, pending_d;
  logic rise, fall;

  always_comb begin
    start_dly_d = i_start;
    rise        = i_start & ~start_dly_q;
    fall        = ~i_start & start_dly_q;
    pending_d   = pending_q;
    if (i_grant || fall) pending_d = 1'b0;
    // a fresh request while the same client is being served queues it again
    if (rise) pending_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      start_dly_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      start_dly_q <= start_dly_d;
      pending_q   <= pending_d;
    end
  end

  // a request withdrawn this cycle must not win arbitration
  assign o_pending = pending_q & ~fall;
  assign o_abort   = fall;

endmodule

// File: rtl/sdram_wr_tunnel_mux.sv
// Round-robin mux of two write clients onto SDRAM write port 3.
//   state  | meaning
//   IDLE   | no job, arbitrating pending requests
//   LAUNCH | counting out the delayed, stretched start pulse
//   XFER   | forwarding beats of the granted client
//   FLUSH  | all beats sent, waiting for port idle before done
//   ABORT  | client withdrew, waiting for port idle, no done
module sdram_wr_tunnel_mux
  import sdram_arb_pkg::*;
#(
  parameter int START_DLY = 3,
  parameter int START_W   = 5
) (
  input  logic i_clk,
  input  logic i_rst,
  sdram_wr_tunnel_mux_if.slave bus
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_ON   = CNT_W'(START_DLY);
  localparam logic [CNT_W-1:0] CNT_OFF  = CNT_W'(START_DLY + START_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_DLY + START_W - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  beats_q, beats_d;
  logic [ADDR_W-1:0] addrs_q, addrs_d;
  logic [LEN_W-1:0]  lens_q, lens_d;
  logic              tunnel_id_q, tunnel_id_d;
  logic              last_grant_q, last_grant_d;
  logic              start_q, start_d;
  logic [1:0]        done_q, done_d;

  logic              pend_0, pend_1, abort_0, abort_1;
  logic              grant_0, grant_1;
  logic              any_pend, win;
  logic [LEN_W-1:0]  win_len;
  logic              g_vld, g_abort, g_req, beat_acc, in_xfer;
  logic [DATA_W-1:0] g_data;
  logic [LEN_W-1:0]  beats_inc;

  wr_client_req_edge u_edge_0 (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (bus.i_wr_0_start),
    .i_grant   (grant_0),
    .o_pending (pend_0),
    .o_abort   (abort_0)
  );

  wr_client_req_edge u_edge_1 (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (bus.i_wr_1_start),
    .i_grant   (grant_1),
    .o_pending (pend_1),
    .o_abort   (abort_1)
  );

  assign any_pend  = pend_0 | pend_1;
  assign win       = rr_pick(pend_0, pend_1, last_grant_q);
  assign win_len   = win ? bus.i_wr_1_lengths : bus.i_wr_0_lengths;
  assign in_xfer   = (state_q == XFER);
  assign g_vld     = tunnel_id_q ? bus.i_wr_1_data_vld : bus.i_wr_0_data_vld;
  assign g_data    = tunnel_id_q ? bus.i_wr_1_data : bus.i_wr_0_data;
  assign g_abort   = tunnel_id_q ? abort_1 : abort_0;
  assign g_req     = in_xfer & bus.i_mem_wr3_data_req & (beats_q < lens_q);
  assign beat_acc  = g_req & g_vld;
  assign beats_inc = beats_q + 32'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (any_pend) state_d = (win_len == '0) ? FLUSH : LAUNCH;
      LAUNCH: begin
        if (g_abort)                state_d = ABORT;
        else if (cnt_q == CNT_LAST) state_d = XFER;
      end
      XFER: begin
        if (g_abort)                                state_d = ABORT;
        else if (beat_acc && beats_inc == lens_q)   state_d = FLUSH;
      end
      FLUSH:  if (bus.i_mem_wr3_idle) state_d = IDLE;
      ABORT:  if (bus.i_mem_wr3_idle) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    beats_d      = beats_q;
    addrs_d      = addrs_q;
    lens_d       = lens_q;
    tunnel_id_d  = tunnel_id_q;
    last_grant_d = last_grant_q;
    done_d       = 2'b00;
    grant_0      = 1'b0;
    grant_1      = 1'b0;
    if (state_q == IDLE && any_pend) begin
      addrs_d     = win ? bus.i_wr_1_addrs : bus.i_wr_0_addrs;
      lens_d      = win_len;
      tunnel_id_d = win;
      cnt_d       = '0;
      beats_d     = '0;
      grant_0     = ~win;
      grant_1     = win;
    end
    if (state_q == LAUNCH) cnt_d = cnt_q + 8'd1;
    if (beat_acc) beats_d = beats_inc;
    if (state_q == FLUSH && bus.i_mem_wr3_idle) begin
      done_d[tunnel_id_q] = 1'b1;
      last_grant_d        = tunnel_id_q;
    end
    // start is registered from the next count so it rises exactly START_DLY cycles after grant
    start_d = (state_d == LAUNCH) && (cnt_d >= CNT_ON) && (cnt_d < CNT_OFF);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q        <= '0;
      beats_q      <= '0;
      addrs_q      <= '0;
      lens_q       <= '0;
      tunnel_id_q  <= 1'b0;
      last_grant_q <= 1'b1;
      start_q      <= 1'b0;
      done_q       <= 2'b00;
    end else begin
      cnt_q        <= cnt_d;
      beats_q      <= beats_d;
      addrs_q      <= addrs_d;
      lens_q       <= lens_d;
      tunnel_id_q  <= tunnel_id_d;
      last_grant_q <= last_grant_d;
      start_q      <= start_d;
      done_q       <= done_d;
    end
  end

  assign bus.o_tunnel_id        = tunnel_id_q;
  assign bus.o_busy             = (state_q != IDLE);
  assign bus.o_mem_wr3_start    = start_q;
  assign bus.o_mem_wr3_addrs    = addrs_q;
  assign bus.o_mem_wr3_lens     = lens_q;
  assign bus.o_mem_wr3_data_vld = in_xfer & g_vld;
  assign bus.o_mem_wr3_data     = in_xfer ? g_data : '0;
  assign bus.o_wr_0_data_req    = g_req & ~tunnel_id_q;
  assign bus.o_wr_1_data_req    = g_req & tunnel_id_q;
  assign bus.o_wr_0_done        = done_q[0];
  assign bus.o_wr_1_done        = done_q[1];

endmodule

// File: tb/tb_sdram_wr_tunnel_mux.sv
// Directed bench for sdram_wr_tunnel_mux with START_DLY=3, START_W=5.
module tb_sdram_wr_tunnel_mux;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  sdram_wr_tunnel_mux_if bus();

  sdram_wr_tunnel_mux #(.START_DLY(3), .START_W(5)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int done_log[$];
  int n_start = 0;
  int n_req1  = 0;

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (bus.o_wr_0_done)     done_log.push_back(0);
      if (bus.o_wr_1_done)     done_log.push_back(1);
      if (bus.o_mem_wr3_start) n_start++;
      if (bus.o_wr_1_data_req) n_req1++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int k = 0;
    while (done_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(done_log.size() >= n), 32'd1);
  endtask

  task automatic clear_inputs();
    bus.i_wr_0_start = 0; bus.i_wr_0_addrs = '0; bus.i_wr_0_lengths = '0;
    bus.i_wr_0_data_vld = 0; bus.i_wr_0_data = '0;
    bus.i_wr_1_start = 0; bus.i_wr_1_addrs = '0; bus.i_wr_1_lengths = '0;
    bus.i_wr_1_data_vld = 0; bus.i_wr_1_data = '0;
    bus.i_mem_wr3_data_req = 0; bus.i_mem_wr3_idle = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    logic [5:0] pat;
    logic req_at4, vld_at4;

    // ---- reset state
    i_rst = 1;
    clear_inputs();
    tick(2);
    chk("rst_busy",  32'(bus.o_busy), 32'd0);
    chk("rst_start", 32'(bus.o_mem_wr3_start), 32'd0);
    chk("rst_tid",   32'(bus.o_tunnel_id), 32'd0);
    chk("rst_addrs", 32'(bus.o_mem_wr3_addrs), 32'd0);
    chk("rst_done",  32'({bus.o_wr_1_done, bus.o_wr_0_done}), 32'd0);

    // ---- client 0, len 4, full throughput
    i_rst = 0;
    bus.i_mem_wr3_data_req = 1;
    bus.i_wr_0_addrs = 21'h00100; bus.i_wr_0_lengths = 32'd4;
    bus.i_wr_0_data_vld = 1; bus.i_wr_0_data = 16'hA000;
    bus.i_wr_0_start = 1;
    n_start = 0; n_req1 = 0; done_log.delete();
    tick();
    chk("t1_busy_pre", 32'(bus.o_busy), 32'd0);
    tick();
    chk("t1_busy",  32'(bus.o_busy), 32'd1);
    chk("t1_tid",   32'(bus.o_tunnel_id), 32'd0);
    chk("t1_addrs", 32'(bus.o_mem_wr3_addrs), 32'h00100);
    chk("t1_lens",  bus.o_mem_wr3_lens, 32'd4);
    tick(2);
    chk("t1_start_early", 32'(bus.o_mem_wr3_start), 32'd0);
    tick();
    chk("t1_start_first", 32'(bus.o_mem_wr3_start), 32'd1);
    tick(4);
    chk("t1_start_last", 32'(bus.o_mem_wr3_start), 32'd1);
    tick();
    chk("t1_start_off", 32'(bus.o_mem_wr3_start), 32'd0);
    beats = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.o_mem_wr3_data_vld)
        chk("t1_data", 32'(bus.o_mem_wr3_data), 32'(16'hA000 + 16'(beats)));
      if (bus.o_wr_0_data_req && bus.o_mem_wr3_data_vld) begin
        beats++;
        bus.i_wr_0_data = 16'hA000 + 16'(beats);
      end
      tick();
    end
    chk("t1_beats",   32'(beats), 32'd4);
    chk("t1_nstart",  32'(n_start), 32'd5);
    chk("t1_req_off", 32'(bus.o_wr_0_data_req), 32'd0);
    chk("t1_vld_off", 32'(bus.o_mem_wr3_data_vld), 32'd0);
    chk("t1_flush_busy", 32'(bus.o_busy), 32'd1);
    chk("t1_req1",    32'(n_req1), 32'd0);
    chk("t1_no_done_early", 32'(done_log.size()), 32'd0);
    bus.i_mem_wr3_idle = 1;
    tick();
    chk("t1_done",      32'(bus.o_wr_0_done), 32'd1);
    chk("t1_busy_idle", 32'(bus.o_busy), 32'd0);
    tick();
    chk("t1_done_1cyc", 32'(bus.o_wr_0_done), 32'd0);
    chk("t1_done_cnt",  32'(done_log.size()), 32'd1);
    bus.i_wr_0_start = 0; bus.i_wr_0_data_vld = 0; bus.i_mem_wr3_idle = 0;

    // ---- simultaneous requests after reset, then alternation
    i_rst = 1;
    tick(2);
    i_rst = 0;
    done_log.delete();
    bus.i_wr_0_lengths = 32'd2; bus.i_wr_1_lengths = 32'd2;
    bus.i_wr_0_data_vld = 1; bus.i_wr_1_data_vld = 1;
    bus.i_mem_wr3_data_req = 1; bus.i_mem_wr3_idle = 1;
    bus.i_wr_0_start = 1; bus.i_wr_1_start = 1;
    wait_log(2, 80, "t2_pair_timeout");
    chk("t2_first",  32'(done_log[0]), 32'd0);
    chk("t2_second", 32'(done_log[1]), 32'd1);
    bus.i_wr_0_start = 0; bus.i_wr_1_start = 0;
    tick();
    bus.i_wr_0_start = 1; bus.i_wr_1_start = 1;
    wait_log(3, 80, "t2_rr0_timeout");
    bus.i_wr_0_start = 0;
    tick();
    bus.i_wr_0_start = 1;
    wait_log(5, 120, "t2_rr_timeout");
    chk("t2_rr_a", 32'(done_log[2]), 32'd0);
    chk("t2_rr_b", 32'(done_log[3]), 32'd1);
    chk("t2_rr_c", 32'(done_log[4]), 32'd0);
    bus.i_wr_0_start = 0; bus.i_wr_1_start = 0;
    bus.i_wr_0_data_vld = 0; bus.i_wr_1_data_vld = 0; bus.i_mem_wr3_idle = 0;
    tick(2);

    // ---- client 1 zero-length job
    done_log.delete(); n_start = 0;
    bus.i_wr_1_lengths = 32'd0; bus.i_wr_1_addrs = 21'h1ABCD;
    bus.i_wr_1_start = 1;
    tick(2);
    chk("t3_busy",  32'(bus.o_busy), 32'd1);
    chk("t3_tid",   32'(bus.o_tunnel_id), 32'd1);
    chk("t3_addrs", 32'(bus.o_mem_wr3_addrs), 32'h1ABCD);
    chk("t3_lens",  bus.o_mem_wr3_lens, 32'd0);
    tick(4);
    chk("t3_wait_busy", 32'(bus.o_busy), 32'd1);
    chk("t3_no_done",   32'(done_log.size()), 32'd0);
    bus.i_mem_wr3_idle = 1;
    tick();
    chk("t3_done", 32'(bus.o_wr_1_done), 32'd1);
    chk("t3_idle", 32'(bus.o_busy), 32'd0);
    tick();
    chk("t3_nstart", 32'(n_start), 32'd0);
    chk("t3_done_1cyc", 32'(bus.o_wr_1_done), 32'd0);
    bus.i_wr_1_start = 0; bus.i_mem_wr3_idle = 0;
    tick();

    // ---- client 0 len 3 with port req toggling 1,0,1,1
    bus.i_wr_0_lengths = 32'd3; bus.i_wr_0_addrs = 21'h00333;
    bus.i_wr_0_data_vld = 1; bus.i_wr_0_data = 16'hB000;
    bus.i_mem_wr3_data_req = 0;
    bus.i_wr_0_start = 1;
    tick(10);
    pat = 6'b111101;
    beats = 0; req_at4 = 1'b1; vld_at4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.i_mem_wr3_data_req = pat[i];
      @(negedge i_clk);
      if (bus.o_wr_0_data_req && bus.o_mem_wr3_data_vld) beats++;
      if (i == 4) begin
        req_at4 = bus.o_wr_0_data_req;
        vld_at4 = bus.o_mem_wr3_data_vld;
      end
      tick();
    end
    chk("t4_beats",   32'(beats), 32'd3);
    chk("t4_req_gate", 32'(req_at4), 32'd0);
    chk("t4_vld_gate", 32'(vld_at4), 32'd0);
    chk("t4_lens",    bus.o_mem_wr3_lens, 32'd3);
    bus.i_mem_wr3_idle = 1;
    tick();
    chk("t4_done", 32'(bus.o_wr_0_done), 32'd1);
    bus.i_wr_0_start = 0; bus.i_wr_0_data_vld = 0; bus.i_mem_wr3_idle = 0;
    bus.i_mem_wr3_data_req = 1;
    tick();

    // ---- client 1 aborts after 2 of 8 beats
    done_log.delete();
    bus.i_wr_1_lengths = 32'd8; bus.i_wr_1_addrs = 21'h00800;
    bus.i_wr_1_data_vld = 1; bus.i_wr_1_data = 16'hC000;
    bus.i_wr_1_start = 1;
    tick(10);
    chk("t5_beat1", 32'(bus.o_mem_wr3_data_vld & bus.o_wr_1_data_req), 32'd1);
    tick();
    chk("t5_beat2", 32'(bus.o_mem_wr3_data_vld & bus.o_wr_1_data_req), 32'd1);
    bus.i_wr_1_start = 0;
    tick();
    chk("t5_vld_stop", 32'(bus.o_mem_wr3_data_vld), 32'd0);
    chk("t5_req_stop", 32'(bus.o_wr_1_data_req), 32'd0);
    chk("t5_busy",     32'(bus.o_busy), 32'd1);
    tick(3);
    chk("t5_hold", 32'(bus.o_busy), 32'd1);
    bus.i_mem_wr3_idle = 1;
    tick();
    chk("t5_idle", 32'(bus.o_busy), 32'd0);
    tick(3);
    chk("t5_no_done", 32'(done_log.size()), 32'd0);
    bus.i_wr_1_data_vld = 0; bus.i_mem_wr3_idle = 0;

    // ---- reset in the middle of XFER with client 1 pending
    done_log.delete();
    bus.i_wr_0_lengths = 32'd4; bus.i_wr_0_addrs = 21'h00444;
    bus.i_wr_0_data_vld = 1; bus.i_wr_0_data = 16'hD000;
    bus.i_wr_0_start = 1;
    tick(3);
    bus.i_wr_1_lengths = 32'd2; bus.i_wr_1_data_vld = 1;
    bus.i_wr_1_start = 1;
    tick(8);
    chk("t6_in_xfer", 32'(bus.o_wr_0_data_req), 32'd1);
    i_rst = 1;
    bus.i_wr_0_start = 0; bus.i_wr_1_start = 0;
    tick();
    chk("t6_busy",  32'(bus.o_busy), 32'd0);
    chk("t6_vld",   32'(bus.o_mem_wr3_data_vld), 32'd0);
    chk("t6_data",  32'(bus.o_mem_wr3_data), 32'd0);
    chk("t6_req",   32'({bus.o_wr_1_data_req, bus.o_wr_0_data_req}), 32'd0);
    chk("t6_start", 32'(bus.o_mem_wr3_start), 32'd0);
    chk("t6_addrs", 32'(bus.o_mem_wr3_addrs), 32'd0);
    chk("t6_lens",  bus.o_mem_wr3_lens, 32'd0);
    chk("t6_tid",   32'(bus.o_tunnel_id), 32'd0);
    chk("t6_done",  32'({bus.o_wr_1_done, bus.o_wr_0_done}), 32'd0);
    i_rst = 0;
    n_start = 0;
    bus.i_mem_wr3_idle = 1;
    tick(20);
    chk("t6_not_served", 32'(bus.o_busy), 32'd0);
    chk("t6_nstart",     32'(n_start), 32'd0);
    chk("t6_no_done",    32'(done_log.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
